// File: rtl/arb_pkg.sv
// Shared types and helpers for the LRG matrix arbiter.
// Supports up to ARB_MAX_W requesters.
package arb_pkg;

    localparam int ARB_MAX_W = 32;

    typedef logic [ARB_MAX_W-1:0][ARB_MAX_W-1:0] arb_mat_t;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    // Row i has bit j set for every j below i: lower index starts with higher priority.
    function automatic arb_mat_t arb_reset_matrix(input int width);
        arb_mat_t m;
        m = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            for (int j = 0; j < ARB_MAX_W; j++) begin
                if ((i < width) && (j < i)) begin
                    m[i][j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // OR of set-bit positions; exact for one-hot input, 0 for all-zero input.
    function automatic int onehot2idx(input logic [ARB_MAX_W-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_matrix.sv
// Combinational matrix select: a requester wins when no active requester
// holds priority over it. Yields one-hot output for a consistent matrix.
module arb_matrix #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]            i_req,
    input  logic [WIDTH-1:0][WIDTH-1:0] i_mat,
    output logic [WIDTH-1:0]            o_grant
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
        assign o_grant[gi] = i_req[gi] & ~|(i_req & i_mat[gi]);
    end

endmodule

// File: rtl/arb_matrix_ctrl.sv
// Least-recently-granted arbiter owning the priority matrix.
// Optional packet lock enabled by defining ARB_MATRIX_CTRL_LOCK_EN:
// a non-last beat locks the grant to its requester until the last beat.
module arb_matrix_ctrl
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] v_req,
    input  logic [WIDTH-1:0] v_last,
    input  logic             out_ready,
    output logic [WIDTH-1:0] v_grant,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic             lock_busy
);

    localparam arb_mat_t RST_MAT = arb_reset_matrix(WIDTH);

    // r_mat[i][j] = 1: requester j beats requester i. Diagonal stays 0.
    logic [WIDTH-1:0][WIDTH-1:0] r_mat;
    logic [WIDTH-1:0]            w_eff_req;
    logic                        w_xfer;
    logic                        w_release;

    arb_matrix #(.WIDTH(WIDTH)) u_sel (
        .i_req   (w_eff_req),
        .i_mat   (r_mat),
        .o_grant (v_grant)
    );

    assign grant_vld = |v_grant;
    assign grant_idx = IDX_W'(onehot2idx(ARB_MAX_W'(v_grant)));
    assign w_xfer    = grant_vld & out_ready;

    // On a releasing transfer the winner loses to everyone (row set) and
    // nobody loses to it any more (column cleared); other pairs keep order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    r_mat[i][j] <= RST_MAT[i][j];
                end
            end
        end else if (w_release) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (i != j) begin
                        if (v_grant[i]) begin
                            r_mat[i][j] <= 1'b1;
                        end else if (v_grant[j]) begin
                            r_mat[i][j] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef ARB_MATRIX_CTRL_LOCK_EN

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_idx_next;
    logic [WIDTH-1:0] w_lock_oh;
    logic             w_last;

    assign w_lock_oh = WIDTH'(1) << r_lock_idx;
    assign w_last    = |(v_grant & v_last);
    // While locked, only the owner may be presented to the select.
    assign w_eff_req = (r_state == ARB_LOCK) ? (v_req & w_lock_oh) : v_req;
    assign lock_busy = (r_state == ARB_LOCK);

    // State and lock owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end

    // Next-state: a non-last beat in IDLE locks; a last beat releases.
    always_comb begin
        w_state_next    = r_state;
        w_lock_idx_next = r_lock_idx;
        w_release       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_release = 1'b1;
                    end else begin
                        w_state_next    = ARB_LOCK;
                        w_lock_idx_next = grant_idx;
                    end
                end
            end
            ARB_LOCK: begin
                if (w_xfer && w_last) begin
                    w_release    = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

`else

    logic w_unused_last;

    assign w_unused_last = ^v_last;
    assign w_eff_req     = v_req;
    assign w_release     = w_xfer;
    assign lock_busy     = 1'b0;

`endif

endmodule

// File: tb/tb_arb_matrix_ctrl.sv
// Self-checking bench for arb_matrix_ctrl: directed literal checks plus
// randomized traffic compared against an LRG ordering-queue model.
module tb_arb_matrix_ctrl;

    localparam int W = 4;
`ifdef ARB_MATRIX_CTRL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] v_req = '0;
    logic [W-1:0] v_last = '0;
    logic         out_ready = 1'b0;
    logic [W-1:0] v_grant;
    logic         grant_vld;
    logic [1:0]   grant_idx;
    logic         lock_busy;

    int tests = 0;
    int fails = 0;

    // Model: order[0] is the highest-priority requester; release moves to back.
    int order[$];
    bit m_locked;
    int m_lidx;

    always #5 clk = ~clk;

    arb_matrix_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .v_req     (v_req),
        .v_last    (v_last),
        .out_ready (out_ready),
        .v_grant   (v_grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .lock_busy (lock_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        order    = {0, 1, 2, 3};
        m_locked = 1'b0;
        m_lidx   = 0;
    endfunction

    function automatic void model_release(input int w);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == w) begin
                order.delete(k);
                break;
            end
        end
        order.push_back(w);
    endfunction

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin : cmp
        int w;
        int exp_g;
        if (rst) model_reset();
        w = -1;
        if (m_locked) begin
            if (v_req[m_lidx]) w = m_lidx;
        end else begin
            for (int k = 0; k < order.size(); k++) begin
                if (w < 0 && v_req[order[k]]) w = order[k];
            end
        end
        exp_g = (w >= 0) ? (1 << w) : 0;
        check("m_grant", int'(v_grant), exp_g);
        check("m_vld", int'(grant_vld), (w >= 0) ? 1 : 0);
        check("m_idx", int'(grant_idx), (w >= 0) ? w : 0);
        check("m_lock", int'(lock_busy), int'(m_locked));
        if (!rst && w >= 0 && out_ready) begin
            if (!LOCK || v_last[w]) begin
                model_release(w);
                m_locked = 1'b0;
            end else begin
                m_locked = 1'b1;
                m_lidx   = w;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; v_req = '0; v_last = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_vld", int'(grant_vld), 0);
        check("rst_grant", int'(v_grant), 0);
        check("rst_idx", int'(grant_idx), 0);
        check("rst_lock", int'(lock_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic [W-1:0] req, input logic [W-1:0] last, input logic rdy);
        @(posedge clk); #1;
        v_req = req; v_last = last; out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};

        // Round robin with all requesting.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            check("rr_idx", int'(grant_idx), exp_rr[k]);
        end

        // Aging between requesters 0 and 2.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0101, 4'b1111, 1'b1);
            check("age_idx", int'(grant_idx), (k % 2 == 0) ? 0 : 2);
        end

        // Backpressure holds grant and priority.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(4'b0110, 4'b1111, 1'b0);
            check("bp_hold", int'(v_grant), 4'b0010);
        end
        step(4'b0110, 4'b1111, 1'b1);
        check("bp_xfer", int'(v_grant), 4'b0010);
        step(4'b0110, 4'b1111, 1'b0);
        check("bp_next", int'(v_grant), 4'b0100);

`ifdef ARB_MATRIX_CTRL_LOCK_EN
        // Three-beat packet from requester 1.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1);
        check("pkt_b1_idx", int'(grant_idx), 1);
        check("pkt_b1_lock", int'(lock_busy), 0);
        step(4'b1111, 4'b0000, 1'b1);
        check("pkt_b2_idx", int'(grant_idx), 1);
        check("pkt_b2_lock", int'(lock_busy), 1);
        step(4'b1111, 4'b0010, 1'b1);
        check("pkt_b3_idx", int'(grant_idx), 1);
        check("pkt_b3_lock", int'(lock_busy), 1);
        step(4'b1111, 4'b1111, 1'b0);
        check("pkt_after", int'(grant_idx), 0);
        check("pkt_after_lock", int'(lock_busy), 0);

        // Owner drops request mid-packet.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(4'b1101, 4'b1111, 1'b1);
            check("drop_vld", int'(grant_vld), 0);
            check("drop_lock", int'(lock_busy), 1);
        end
        step(4'b1111, 4'b1111, 1'b1);
        check("resume_idx", int'(grant_idx), 1);
        step(4'b1111, 4'b1111, 1'b0);
        check("resume_next", int'(grant_idx), 0);
`endif

        // Reset in the middle of traffic restores reset priority.
        do_reset();
        step(4'b0010, 4'b1111, 1'b1);
        check("mr_first", int'(grant_idx), 1);
        step(4'b0010, 4'b0000, 1'b1);
        check("mr_second", int'(grant_idx), 1);
        @(posedge clk); #1;
        rst = 1'b1; v_req = 4'b1010; v_last = 4'b1111; out_ready = 1'b0;
        #1;
        check("mr_lock_drop", int'(lock_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_grant", int'(grant_idx), 1);

        // Random traffic checked by the model process.
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 149) == 0);
            v_req     = 4'($urandom);
            v_last    = 4'($urandom) | 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        v_req = '0; out_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
